// File: rtl/fp_sqrt_scheduler_if.sv
// ---------------------------------------------------------------------------
// fp_sqrt_scheduler_if
// Bundles the request/response bus between NUM_REQ clients and the scheduler,
// and the start/done handshake between the scheduler and the shared sqrt core.
//   req_valid / req_data   : client operation requests and operands
//   req_ready              : one-hot accept pulse back to the granted client
//   resp_valid / resp_data : one-hot response pulse and its result
//   resp_err               : error flag, qualified by resp_valid
//   sqrt_start / operand   : launch handshake to the core
//   sqrt_done / result     : completion handshake from the core
//   busy                   : scheduler is not idle
// Modports: slave = scheduler side, master = clients plus core side.
// ---------------------------------------------------------------------------
interface fp_sqrt_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]         resp_data;
   logic                      resp_err;
   logic                      sqrt_start;
   logic [DATA_W-1:0]         sqrt_operand;
   logic                      sqrt_done;
   logic [DATA_W-1:0]         sqrt_result;
   logic                      busy;

   modport slave (
      input  req_valid, req_data, sqrt_done, sqrt_result,
      output req_ready, resp_valid, resp_data, resp_err,
             sqrt_start, sqrt_operand, busy
   );

   modport master (
      output req_valid, req_data, sqrt_done, sqrt_result,
      input  req_ready, resp_valid, resp_data, resp_err,
             sqrt_start, sqrt_operand, busy
   );
endinterface

// File: rtl/fp_sqrt_scheduler.sv
// ---------------------------------------------------------------------------
// fp_sqrt_scheduler
// Shares one floating-point square-root core among NUM_REQ requesters.
// Round-robin grant in IDLE, operand capture, one-cycle start pulse, wait for
// the core (with watchdog), then a one-cycle response to the granted client.
// Negative non-zero operands are answered with a quiet NaN and the error flag
// without touching the core.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fp_sqrt_scheduler_if.slave (client request/response bus and the
//          core start/done handshake, see the interface header)
// ---------------------------------------------------------------------------
module fp_sqrt_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 63
) (
   input logic                 clk,
   input logic                 rst,
   fp_sqrt_scheduler_if.slave  bus
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int SW    = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int EXP_W = (DATA_W == 64) ? 11 : (DATA_W == 16) ? 5 : 8;
   localparam int MAN_W = DATA_W - 1 - EXP_W;
   localparam logic [TMR_W-1:0]   T_MAX = TMR_W'(TIMEOUT);
   localparam logic [NUM_REQ-1:0] ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   grant;
   logic [TMR_W-1:0]   timer;
   logic               err_reg;
   logic [DATA_W-1:0]  op_reg;
   logic [DATA_W-1:0]  res_reg;

   logic               arb_found;
   logic [PTR_W-1:0]   arb_idx;
   logic [SW-1:0]      arb_scan;
   logic [DATA_W-1:0]  arb_op;

   // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
   function automatic logic [DATA_W-1:0] qnan();
      return {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   endfunction

   // -0 is a legal operand; only a set sign with non-zero magnitude is rejected.
   function automatic logic is_neg_nonzero(input logic [DATA_W-1:0] op);
      return op[DATA_W-1] & (|op[DATA_W-2:0]);
   endfunction

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = rr_ptr;
      arb_scan  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_scan = {1'b0, rr_ptr} + SW'(k);
         if (arb_scan >= SW'(NUM_REQ))
            arb_scan = arb_scan - SW'(NUM_REQ);
         if (!arb_found && bus.req_valid[arb_scan[PTR_W-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = arb_scan[PTR_W-1:0];
         end
      end
   end

   assign arb_op = bus.req_data[int'(arb_idx)*DATA_W +: DATA_W];

   // Accept is combinational in IDLE; held low while reset is asserted.
   assign bus.req_ready = (state == S_IDLE && arb_found && !rst) ? (ONE << arb_idx) : '0;

   // Control: state, arbitration pointer, grant, watchdog, error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         rr_ptr  <= '0;
         grant   <= '0;
         timer   <= '0;
         err_reg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (arb_found) begin
                  grant <= arb_idx;
                  if (is_neg_nonzero(arb_op)) begin
                     err_reg <= 1'b1;
                     state   <= S_RESPOND;
                  end else begin
                     err_reg <= 1'b0;
                     state   <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + TMR_W'(1);
               // Completion takes priority over a watchdog expiry in the same cycle.
               if (bus.sqrt_done) begin
                  err_reg <= 1'b0;
                  state   <= S_RESPOND;
               end else if (timer == T_MAX) begin
                  err_reg <= 1'b1;
                  state   <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + PTR_W'(1);
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Data: operand capture at accept, result capture at done/abort/reject.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && arb_found) begin
         op_reg <= arb_op;
         if (is_neg_nonzero(arb_op))
            res_reg <= qnan();
      end else if (state == S_WAIT) begin
         if (bus.sqrt_done)
            res_reg <= bus.sqrt_result;
         else if (timer == T_MAX)
            res_reg <= qnan();
      end
   end

   // Outputs decoded from registered state; data outputs are zero when unqualified.
   assign bus.sqrt_start   = (state == S_LAUNCH);
   assign bus.sqrt_operand = (state == S_LAUNCH || state == S_WAIT) ? op_reg : '0;
   assign bus.resp_valid   = (state == S_RESPOND) ? (ONE << grant) : '0;
   assign bus.resp_data    = (state == S_RESPOND) ? res_reg : '0;
   assign bus.resp_err     = (state == S_RESPOND) & err_reg;
   assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_fp_sqrt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fp_sqrt_scheduler
// Directed bench for fp_sqrt_scheduler (NUM_REQ=4, DATA_W=32, TIMEOUT=63).
// A small behavioural core answers each start pulse after core_k cycles with
// core_res. A table of single operations is applied first, followed by
// hand-written sequences for round-robin, watchdog and reset corner cases.
// ---------------------------------------------------------------------------
module tb_fp_sqrt_scheduler;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 63;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_sqrt_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   fp_sqrt_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Core model and event counters.
   logic        core_en   = 1'b1;
   int          core_k    = 1;
   logic [31:0] core_res  = '0;
   logic        core_busy = 1'b0;
   int          core_cnt  = 0;
   logic        core_done = 1'b0;
   logic [31:0] core_out  = '0;
   logic        man_done  = 1'b0;
   logic [31:0] man_res   = '0;
   int          n_start   = 0;
   int          n_resp    = 0;

   assign bus.sqrt_done   = core_done | man_done;
   assign bus.sqrt_result = man_done ? man_res : core_out;

   always @(negedge clk) begin
      core_done = 1'b0;
      if (core_busy) begin
         core_cnt = core_cnt - 1;
         if (core_cnt == 0) begin
            core_done = 1'b1;
            core_out  = core_res;
            core_busy = 1'b0;
         end
      end
      if (bus.sqrt_start) begin
         n_start = n_start + 1;
         if (core_en) begin
            core_busy = 1'b1;
            core_cnt  = core_k;
         end
      end
      if (bus.resp_valid != 0) n_resp = n_resp + 1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      logic [3:0]   valid;
      logic [127:0] data;
      int           k;
      logic [31:0]  cres;
      logic [3:0]   gnt;
      logic [31:0]  rdata;
      logic         rerr;
      int           lat;
      int           starts;
      logic [31:0]  opnd;
   } vec_t;

   // Applies one operation, waits for its response and checks every observable.
   task automatic run_vec(input string tag, input vec_t v);
      int          t;
      int          lat;
      int          s0;
      logic [3:0]  g;
      logic [31:0] opnd;
      s0       = n_start;
      core_k   = v.k;
      core_res = v.cres;
      bus.req_valid = v.valid;
      bus.req_data  = v.data;
      #1;
      t = 0;
      while (bus.req_ready == 0 && t < 20) begin
         step(); #1; t++;
      end
      g = bus.req_ready;
      chk({tag, " grant"}, 32'(g), 32'(v.gnt));
      step();
      bus.req_valid = '0;
      #1;
      lat  = 1;
      opnd = '0;
      while (bus.resp_valid == 0 && lat < 100) begin
         if (bus.sqrt_start) opnd = bus.sqrt_operand;
         step(); #1; lat++;
      end
      chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'(v.gnt));
      chk({tag, " resp_data"}, bus.resp_data, v.rdata);
      chk({tag, " resp_err"}, 32'(bus.resp_err), 32'(v.rerr));
      chk({tag, " latency"}, 32'(lat), 32'(v.lat));
      chk({tag, " starts"}, 32'(n_start - s0), 32'(v.starts));
      chk({tag, " operand"}, opnd, v.opnd);
      step(); #1;
      chk({tag, " resp_pulse_end"}, 32'(bus.resp_valid), 32'h0);
   endtask

   vec_t tbl[8];
   vec_t tv;

   initial begin
      int          t;
      int          r0;
      logic [3:0]  rr_exp[5];

      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      #2;
      chk("reset busy", 32'(bus.busy), 32'h0);
      chk("reset resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("reset sqrt_start", 32'(bus.sqrt_start), 32'h0);
      chk("reset resp_data", bus.resp_data, 32'h0);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("post-reset busy", 32'(bus.busy), 32'h0);

      //          valid    data (lane3..lane0)                                       k   cres          gnt      rdata         err  lat starts operand
      tbl[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h40800000},                     5,  32'h40000000, 4'b0001, 32'h40000000, 1'b0, 7, 1, 32'h40800000};
      tbl[1] = '{4'b0100, {32'h0, 32'hC0800000, 32'h0, 32'h0},                     1,  32'h0,        4'b0100, QNAN,         1'b1, 1, 0, 32'h0};
      tbl[2] = '{4'b0010, {32'h0, 32'h0, 32'h80000000, 32'h0},                     1,  32'h80000000, 4'b0010, 32'h80000000, 1'b0, 3, 1, 32'h80000000};
      tbl[3] = '{4'b1111, {32'h41100000, 32'h3F800000, 32'h40400000, 32'h41800000}, 2, 32'h3F800000, 4'b0100, 32'h3F800000, 1'b0, 4, 1, 32'h3F800000};
      tbl[4] = '{4'b1001, {32'h42800000, 32'h0, 32'h0, 32'h41800000},              3,  32'h41000000, 4'b1000, 32'h41000000, 1'b0, 5, 1, 32'h42800000};
      tbl[5] = '{4'b0110, {32'h0, 32'h40800000, 32'hFF800000, 32'h0},              1,  32'h0,        4'b0010, QNAN,         1'b1, 1, 0, 32'h0};
      tbl[6] = '{4'b0011, {32'h0, 32'h0, 32'hC0000000, 32'h00000000},              4,  32'h0,        4'b0001, 32'h0,        1'b0, 6, 1, 32'h0};
      tbl[7] = '{4'b1000, {32'h80000001, 32'h0, 32'h0, 32'h0},                     1,  32'h0,        4'b1000, QNAN,         1'b1, 1, 0, 32'h0};

      for (int i = 0; i < 8; i++)
         run_vec($sformatf("vec%0d", i), tbl[i]);

      // Round-robin with every requester holding valid.
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      core_k = 1;
      bus.req_data  = {4{32'h40800000}};
      bus.req_valid = 4'b1111;
      #1;
      for (int i = 0; i < 5; i++) begin
         t = 0;
         while (bus.req_ready == 0 && t < 30) begin
            step(); #1; t++;
         end
         chk($sformatf("rr grant%0d", i), 32'(bus.req_ready), 32'(rr_exp[i]));
         step(); #1;
      end
      bus.req_valid = '0;
      t = 0;
      while (bus.busy && t < 30) begin
         step(); #1; t++;
      end
      chk("rr drained", 32'(bus.busy), 32'h0);

      // Watchdog: core never answers.
      core_en = 1'b0;
      tv = '{4'b0001, {4{32'h40800000}}, 1, 32'h0, 4'b0001, QNAN, 1'b1, TIMEOUT + 3, 1, 32'h40800000};
      run_vec("timeout", tv);
      core_en = 1'b1;

      // Stray done while idle must not disturb the scheduler.
      man_res  = 32'h12345678;
      man_done = 1'b1;
      r0 = n_resp;
      step();
      man_done = 1'b0;
      step(); #1;
      chk("stray done busy", 32'(bus.busy), 32'h0);
      chk("stray done resp", 32'(n_resp - r0), 32'h0);

      // Done on the very cycle the watchdog expires: completion wins.
      tv = '{4'b0001, {4{32'h40800000}}, TIMEOUT + 1, 32'h40000000, 4'b0001, 32'h40000000, 1'b0, TIMEOUT + 3, 1, 32'h40800000};
      run_vec("done_at_limit", tv);
      // Done one cycle too late: watchdog already fired.
      tv = '{4'b0001, {4{32'h40800000}}, TIMEOUT + 2, 32'h40000000, 4'b0001, QNAN, 1'b1, TIMEOUT + 3, 1, 32'h40800000};
      run_vec("done_late", tv);

      // Reset in WAIT abandons the operation and restarts arbitration at 0.
      core_en = 1'b0;
      step();
      bus.req_data  = {4{32'h40800000}};
      bus.req_valid = 4'b0100;
      #1;
      chk("rstwait grant", 32'(bus.req_ready), 32'h4);
      step(); bus.req_valid = '0;
      step(); step(); #1;
      chk("rstwait busy", 32'(bus.busy), 32'h1);
      r0 = n_resp;
      bus.req_valid = 4'b1111;
      #1;
      rst = 1'b1;
      #1;
      chk("rstwait busy0", 32'(bus.busy), 32'h0);
      chk("rstwait ready0", 32'(bus.req_ready), 32'h0);
      chk("rstwait operand0", bus.sqrt_operand, 32'h0);
      chk("rstwait start0", 32'(bus.sqrt_start), 32'h0);
      step(); step(); #1;
      rst = 1'b0;
      #1;
      chk("rstwait regrant", 32'(bus.req_ready), 32'h1);
      chk("rstwait no resp", 32'(n_resp - r0), 32'h0);
      core_en  = 1'b1;
      core_k   = 1;
      core_res = 32'h40000000;
      step();
      bus.req_valid = '0;
      #1;
      t = 0;
      while (bus.resp_valid == 0 && t < 20) begin
         step(); #1; t++;
      end
      chk("rstwait resp_valid", 32'(bus.resp_valid), 32'h1);
      chk("rstwait resp_data", bus.resp_data, 32'h40000000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1);
   end

endmodule
